// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART TX handshake bundle for uart_tx_arbiter.
// slave is the arbiter side; master is the requester/TX environment side.
interface uart_tx_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ack;
    logic [NUM_REQ-1:0]            req_done;
    logic [DATA_WIDTH-1:0]         tx_p_data;
    logic                          tx_data_valid;
    logic                          tx_busy;

    modport slave (
        input  req_valid,
        input  req_data,
        input  tx_busy,
        output req_ack,
        output req_done,
        output tx_p_data,
        output tx_data_valid
    );

    modport master (
        output req_valid,
        output req_data,
        output tx_busy,
        input  req_ack,
        input  req_done,
        input  tx_p_data,
        input  tx_data_valid
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ requesters.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module uart_tx_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                       tx_clk,
    input  logic                       rst,
    uart_tx_arbiter_if.slave           bus,
    output logic                       timeout_err,
    output logic [$clog2(NUM_REQ)-1:0] grant,
    output logic                       arb_busy
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [GW-1:0]         ptr;
    logic [GW-1:0]         ptr_nxt;
    logic [GW-1:0]         grant_nxt;
    logic [GW-1:0]         adv;
    logic [GW-1:0]         win;
    logic                  found;
    logic [DATA_WIDTH-1:0] p_data;
    logic [DATA_WIDTH-1:0] p_data_nxt;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    logic [NUM_REQ-1:0]    done_q;
    logic [NUM_REQ-1:0]    done_nxt;
    logic                  err_nxt;
    logic [NUM_REQ-1:0]    ack;

    // Pointer after a finished or aborted frame.
`ifdef UART_ARB_FIXED_PRIO_EN
    assign adv = '0;
`else
    assign adv = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + GW'(1);
`endif

    // Find the first pending requester at or after ptr, wrapping.
    always_comb begin
        int idx;
        logic [GW-1:0] sel;
        idx   = 0;
        sel   = '0;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = GW'(idx);
            if (!found && bus.req_valid[sel]) begin
                win   = sel;
                found = 1'b1;
            end
        end
    end

    // Next-state and next registered-output logic.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        grant_nxt  = grant;
        p_data_nxt = p_data;
        cnt_nxt    = cnt;
        done_nxt   = '0;
        err_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (found && !bus.tx_busy) begin
                    grant_nxt  = win;
                    p_data_nxt = bus.req_data[int'(win) * DATA_WIDTH +: DATA_WIDTH];
                    state_nxt  = LOAD;
                end
            end
            LOAD: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else begin
                    if (cnt != CW'(BUSY_TIMEOUT)) cnt_nxt = cnt + CW'(1);
                    // Abort on the edge where the count would reach the limit.
                    if (cnt >= CW'(BUSY_TIMEOUT - 1)) begin
                        err_nxt   = 1'b1;
                        ptr_nxt   = adv;
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    done_nxt[grant] = 1'b1;
                    ptr_nxt         = adv;
                    state_nxt       = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge tx_clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            p_data      <= '0;
            cnt         <= '0;
            done_q      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            grant       <= grant_nxt;
            p_data      <= p_data_nxt;
            cnt         <= cnt_nxt;
            done_q      <= done_nxt;
            timeout_err <= err_nxt;
        end
    end

    // Acknowledge decoded from the LOAD state and the granted index.
    always_comb begin
        ack = '0;
        if (state == LOAD) ack[grant] = 1'b1;
    end

    assign bus.req_ack       = ack;
    assign bus.req_done      = done_q;
    assign bus.tx_p_data     = p_data;
    assign bus.tx_data_valid = (state == LOAD);
    assign arb_busy          = (state != IDLE);
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter (`P_DATA_IN`/`DATA_VALID`/`busy_flag` interface) between `NUM_REQ` requesters on the transmit clock domain. It selects requesters round-robin, launches one frame per grant, and tracks the transmitter's busy flag through the frame. It reports acceptance and completion per requester and recovers from a transmitter that never goes busy. It sits between the device's message sources and the UART TX block of each device.

## Interface

- `DATA_WIDTH`, 8, frame payload width; matches the TX block.
- `NUM_REQ`, 4, number of requesters, 2..8.
- `BUSY_TIMEOUT`, 15, cycles allowed in WAIT_BUSY before abort, ≥2.
- `tx_clk` in 1: transmit clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: bit i means requester i has a frame pending; held until `req_ack[i]`.
- `req_data` in NUM_REQ*DATA_WIDTH: payload of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ack` out NUM_REQ: one-hot, 1-cycle pulse when requester i's data is latched.
- `req_done` out NUM_REQ: one-hot, 1-cycle pulse when requester i's frame has finished.
- `tx_p_data` out DATA_WIDTH: drives TX `P_DATA_IN`.
- `tx_data_valid` out 1: drives TX `DATA_VALID`.
- `tx_busy` in 1: from TX `busy_flag`.
- `timeout_err` out 1: 1-cycle pulse on busy-wait abort.
- `grant` out $clog2(NUM_REQ): index of the current or last granted requester.
- `arb_busy` out 1: high whenever the state is not IDLE.

## Operation

- FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE. All outputs are registered or decoded from the state only (Moore).
- IDLE:
  - If `|req_valid` and `tx_busy==0`, select winner g, latch `req_data[g]` into `tx_p_data`, set `grant=g`, and go to LOAD.
  - If `tx_busy==1`, stay in IDLE. The arbiter never asserts `tx_data_valid` while TX is busy, so TX `data_lost` must never assert.
- LOAD:
  - `tx_data_valid=1` and `req_ack[grant]=1` for exactly one cycle.
  - Unconditionally go to WAIT_BUSY and clear the timeout counter.
- WAIT_BUSY:
  - On `tx_busy==1`, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT, pulse `timeout_err`, advance the pointer, and go to IDLE. `req_done` does not pulse on this path.
- WAIT_DONE: on `tx_busy==0`, pulse `req_done[grant]`, advance the pointer, and go to IDLE.
- Round-robin:
  - Pointer `ptr` searches ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1; the first set bit wins.
  - Advance sets `ptr=(grant+1) mod NUM_REQ` (wraps from NUM_REQ-1 to 0).
- The timeout counter is $clog2(BUSY_TIMEOUT+1) bits and saturates.
- `req_valid` dropping after ack has no effect. A requester that re-asserts `req_valid` immediately is eligible only after the current frame ends.
- `req_data` is sampled only on the IDLE→LOAD edge; later changes are ignored.
- Reset values: state IDLE, `ptr=0`, `grant=0`, `tx_p_data=0`, counter 0. `tx_data_valid`, `req_ack`, `req_done`, `timeout_err` and `arb_busy` are all 0.
- Reset mid-frame returns to IDLE immediately; the in-flight frame is abandoned with no `req_done`.

## Timing

- Request seen at edge E0 in IDLE: `tx_data_valid` and `req_ack` are high from E0 to E1.
- TX latches at E1; the FSM enters WAIT_BUSY at E1.
- The earliest next grant is one cycle after `req_done`: IDLE is re-entered at the `req_done` edge and the next LOAD follows one edge later.
- Frame-to-frame gap at the arbiter is 2 cycles beyond the TX frame length.
- `tx_busy` rising at the same edge the counter reaches BUSY_TIMEOUT: busy wins, go to WAIT_DONE, no error.

## Configuration

- `UART_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins; `ptr` is held at 0 and never advances.
  - Undefined (default): round-robin as above.
  - Timeout and handshake behaviour are identical in both modes.

## Test plan

- Single request: `req_valid=4'b0010`, data1=8'hF9; TX model goes busy 1 cycle after valid and stays busy 11 cycles.
  - Required: one `tx_data_valid` pulse with `tx_p_data=8'hF9`, `req_ack=4'b0010`, then `req_done=4'b0010` one cycle after busy falls.
- All four requesting continuously (data 8'h85, 8'h0E, 8'hE3, 8'h80):
  - Default: grants 0,1,2,3,0, `ptr` wraps to 0.
  - With `UART_ARB_FIXED_PRIO_EN`: grants 0,0,0.
- TX never asserts busy: `req_valid=4'b1000`.
  - Required: `timeout_err` pulses 15 cycles after LOAD, no `req_done`, next grant goes to requester 0.
- `tx_busy` held 1 at reset release with `req_valid=4'b0001`.
  - Required: no `tx_data_valid` until busy drops, then LOAD on the following edge.
- Reset asserted in WAIT_DONE.
  - Required: all outputs 0 asynchronously, state IDLE, `ptr=0`; no `req_done` after release.
- Busy rises on the same edge the counter hits 15.
  - Required: WAIT_DONE entered, `timeout_err` stays 0.
